// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the ifu/lsu memory arbiter.
// MEM_ARB_TIMEOUT_EN selects the watchdog build; this package is common to both builds.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    SRC_IFU = 1'b0,
    SRC_LSU = 1'b1
  } src_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Access size encoding, identical to the core's lsu_size field.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_wdog.sv
// Watchdog counter for the arbiter; the module exists only when MEM_ARB_TIMEOUT_EN is defined.
// Counts up while enabled, clear has priority, expired flags LIMIT-1.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_wdog #(
  parameter int LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end

  assign expired = (count == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_arb.sv
// Fixed-priority (LSU over IFU) arbiter putting two core memory ports onto one bus,
// single transaction in flight. MEM_ARB_TIMEOUT_EN adds a watchdog and the sticky err output.
//
// state | meaning
// IDLE  | pick a request, latch its fields
// REQ   | mem_reqValid high, fields held until mem_reqReady
// WAIT  | accepted, waiting for mem_respValid
// RESP  | one-cycle respValid pulse to the requester
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [1:0]          lsu_size,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic                err,
`endif
  output logic                mem_reqValid,
  input  logic                mem_reqReady,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [1:0]          mem_size,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t state, state_next;
  src_t   src;

  logic [ADDR_W-1:0]   req_addr;
  logic [1:0]          req_size;
  logic                req_wen;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wmask;

  logic timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  logic wdog_clear;
  logic wdog_expired;

  assign wdog_clear = (state == IDLE && state_next == REQ) ||
                      (state == REQ  && state_next == WAIT);

  mem_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wdog_clear),
    .enable  (state == REQ || state == WAIT),
    .expired (wdog_expired)
  );

  // Progress in the same cycle always beats the watchdog.
  assign timeout_hit = wdog_expired &&
                       ((state == REQ  && !mem_reqReady) ||
                        (state == WAIT && !mem_respValid));

  always_ff @(posedge clock) begin
    if (reset)            err <= 1'b0;
    else if (timeout_hit) err <= 1'b1;
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (lsu_reqValid || ifu_reqValid) state_next = REQ;
      REQ: begin
        if (mem_reqReady)     state_next = WAIT;
        else if (timeout_hit) state_next = RESP;
      end
      WAIT: begin
        if (mem_respValid)    state_next = RESP;
        else if (timeout_hit) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      src       <= SRC_IFU;
      req_addr  <= '0;
      req_size  <= '0;
      req_wen   <= 1'b0;
      req_wdata <= '0;
      req_wmask <= '0;
      ifu_rdata <= '0;
      lsu_rdata <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (lsu_reqValid) begin
          src       <= SRC_LSU;
          req_addr  <= lsu_addr;
          req_size  <= lsu_size;
          req_wen   <= lsu_wen;
          req_wdata <= lsu_wdata;
          req_wmask <= lsu_wmask;
        end else if (ifu_reqValid) begin
          src       <= SRC_IFU;
          req_addr  <= ifu_addr;
          req_size  <= SIZE_WORD;
          req_wen   <= 1'b0;
          req_wdata <= '0;
          req_wmask <= '0;
        end
      end
      if (state == WAIT && mem_respValid) begin
        if (src == SRC_LSU) lsu_rdata <= mem_rdata;
        else                ifu_rdata <= mem_rdata;
      end else if (timeout_hit) begin
        if (src == SRC_LSU) lsu_rdata <= DATA_W'(TIMEOUT_DATA);
        else                ifu_rdata <= DATA_W'(TIMEOUT_DATA);
      end
    end
  end

  assign mem_reqValid  = (state == REQ);
  assign mem_addr      = req_addr;
  assign mem_size      = req_size;
  assign mem_wen       = req_wen;
  assign mem_wdata     = req_wdata;
  assign mem_wmask     = req_wmask;

  assign ifu_respValid = (state == RESP) && (src == SRC_IFU);
  assign lsu_respValid = (state == RESP) && (src == SRC_LSU);

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: fetch, store, priority, backpressure, reset, and
// (with MEM_ARB_TIMEOUT_EN) the watchdog path.
module tb_mem_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid;
  logic        mem_reqReady;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_addr      (ifu_addr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_addr      (lsu_addr),
    .lsu_size      (lsu_size),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
`ifdef MEM_ARB_TIMEOUT_EN
    .err           (err),
`endif
    .mem_reqValid  (mem_reqValid),
    .mem_reqReady  (mem_reqReady),
    .mem_addr      (mem_addr),
    .mem_size      (mem_size),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_respValid (mem_respValid),
    .mem_rdata     (mem_rdata)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    ifu_reqValid = 0; ifu_addr = 0;
    lsu_reqValid = 0; lsu_addr = 0; lsu_size = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_reqReady = 0; mem_respValid = 0; mem_rdata = 0;
    tick(); tick();
    reset = 1'b0;

    check("rst_reqValid", mem_reqValid, 0);
    check("rst_ifu_resp", ifu_respValid, 0);
    check("rst_lsu_resp", lsu_respValid, 0);
    check("rst_ifu_rdata", ifu_rdata, 0);
    check("rst_lsu_rdata", lsu_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);

    // Fetch with an immediate bus.
    ifu_reqValid = 1; ifu_addr = 32'h8000_0000; mem_reqReady = 1;
    tick();
    check("f_reqValid", mem_reqValid, 1);
    check("f_addr", mem_addr, 32'h8000_0000);
    check("f_wen", mem_wen, 0);
    check("f_size", mem_size, 2'b10);
    tick();
    check("f_wait_reqValid", mem_reqValid, 0);
    mem_respValid = 1; mem_rdata = 32'h0010_0073;
    tick();
    mem_respValid = 0;
    check("f_ifu_resp", ifu_respValid, 1);
    check("f_lsu_resp", lsu_respValid, 0);
    check("f_ifu_rdata", ifu_rdata, 32'h0010_0073);
    ifu_reqValid = 0;
    tick();
    check("f_resp_pulse", ifu_respValid, 0);
    check("f_idle_reqValid", mem_reqValid, 0);

    // Byte store.
    lsu_reqValid = 1; lsu_addr = 32'h8000_0103; lsu_size = 2'b00; lsu_wen = 1;
    lsu_wdata = 32'hAB00_0000; lsu_wmask = 4'b1000;
    tick();
    check("s_addr", mem_addr, 32'h8000_0103);
    check("s_wen", mem_wen, 1);
    check("s_wdata", mem_wdata, 32'hAB00_0000);
    check("s_wmask", mem_wmask, 4'b1000);
    check("s_size", mem_size, 2'b00);
    tick();
    mem_respValid = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_respValid = 0;
    check("s_lsu_resp", lsu_respValid, 1);
    check("s_ifu_resp", ifu_respValid, 0);
    check("s_lsu_rdata", lsu_rdata, 32'h1234_5678);
    check("s_ifu_rdata_kept", ifu_rdata, 32'h0010_0073);
    lsu_reqValid = 0;
    tick();
    check("s_resp_pulse", lsu_respValid, 0);

    // Simultaneous requests: LSU first, IFU after the IDLE cycle.
    ifu_reqValid = 1; ifu_addr = 32'h8000_0004;
    lsu_reqValid = 1; lsu_addr = 32'h8000_0200; lsu_size = 2'b10; lsu_wen = 0;
    lsu_wdata = 32'h5555_5555; lsu_wmask = 4'b0000;
    tick();
    check("p_first_addr", mem_addr, 32'h8000_0200);
    tick();
    mem_respValid = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_respValid = 0;
    check("p_lsu_resp", lsu_respValid, 1);
    check("p_ifu_resp0", ifu_respValid, 0);
    check("p_lsu_rdata", lsu_rdata, 32'hCAFE_0001);
    lsu_reqValid = 0;
    tick();
    check("p_idle_gap", mem_reqValid, 0);
    tick();
    check("p_second_valid", mem_reqValid, 1);
    check("p_second_addr", mem_addr, 32'h8000_0004);
    check("p_second_wdata", mem_wdata, 0);
    check("p_second_wmask", mem_wmask, 0);
    check("p_second_wen", mem_wen, 0);
    tick();
    mem_respValid = 1; mem_rdata = 32'h0000_0013;
    tick();
    mem_respValid = 0;
    check("p_ifu_resp", ifu_respValid, 1);
    check("p_ifu_rdata", ifu_rdata, 32'h0000_0013);
    check("p_lsu_rdata_kept", lsu_rdata, 32'hCAFE_0001);
    ifu_reqValid = 0;
    tick();

    // Backpressure: ready low for 3 REQ cycles, high on the 4th.
    mem_reqReady = 0;
    lsu_reqValid = 1; lsu_addr = 32'h8000_0010; lsu_size = 2'b10; lsu_wen = 1;
    lsu_wdata = 32'h1122_3344; lsu_wmask = 4'hF;
    tick();
    lsu_addr = 32'hFFFF_FFF0; lsu_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_reqReady = 1;
      check("b_valid", mem_reqValid, 1);
      check("b_addr", mem_addr, 32'h8000_0010);
      check("b_wdata", mem_wdata, 32'h1122_3344);
      check("b_wmask", mem_wmask, 4'hF);
      tick();
    end
    check("b_single", mem_reqValid, 0);
    mem_respValid = 1; mem_rdata = 32'h0;
    tick();
    mem_respValid = 0;
    check("b_lsu_resp", lsu_respValid, 1);
    lsu_reqValid = 0;
    tick();
    check("b_idle", mem_reqValid, 0);

    // Reset while in WAIT; stale response afterwards must be ignored.
    ifu_reqValid = 1; ifu_addr = 32'h8000_0020;
    tick();
    tick();
    check("r_in_wait", mem_reqValid, 0);
    reset = 1; ifu_reqValid = 0;
    tick();
    reset = 0;
    check("r_ifu_rdata_clr", ifu_rdata, 0);
    check("r_lsu_rdata_clr", lsu_rdata, 0);
    tick();
    tick();
    mem_respValid = 1; mem_rdata = 32'h7777_7777;
    tick();
    mem_respValid = 0;
    check("r_ifu_resp", ifu_respValid, 0);
    check("r_lsu_resp", lsu_respValid, 0);
    check("r_ifu_rdata", ifu_rdata, 0);
    tick();
    check("r_idle", mem_reqValid, 0);
    check("r_ifu_resp2", ifu_respValid, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: bus never accepts.
    check("t_err0", err, 0);
    mem_reqReady = 0;
    ifu_reqValid = 1; ifu_addr = 32'h8000_0040;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t_req_valid", mem_reqValid, 1);
      check("t_no_resp", ifu_respValid, 0);
      tick();
    end
    check("t_ifu_resp", ifu_respValid, 1);
    check("t_rdata", ifu_rdata, 32'hDEAD_BEEF);
    check("t_err", err, 1);
    ifu_reqValid = 0;
    tick();
    tick();
    check("t_err_sticky", err, 1);
    reset = 1;
    tick();
    reset = 0;
    check("t_err_reset", err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
